// File: rtl/prio_issue_buffer_pkg.sv
// Shared types and one-hot helpers for prio_issue_buffer.
// Optional same-cycle bypass is enabled by defining PRIO_ISSUE_BUFFER_BYPASS_EN.
package prio_issue_buffer_pkg;

    localparam int NumEntries = 8;
    localparam int MaxEntries = 64;
    localparam int MaxIdxW    = $clog2(MaxEntries);

    typedef logic [$clog2(NumEntries)-1:0] slot_idx_t;

    // Vectors are zero-extended to MaxEntries so one helper serves any Entries.
    function automatic logic [MaxEntries-1:0] lowest_one_oh(input logic [MaxEntries-1:0] vec);
        return vec & ~(vec - MaxEntries'(1));
    endfunction

    function automatic logic [MaxIdxW-1:0] oh2bin(input logic [MaxEntries-1:0] oh);
        logic [MaxIdxW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MaxEntries; i++) begin
            if (oh[i]) idx = idx | MaxIdxW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_issue_buffer_pmux.sv
// PriorityMux: returns the data word of the lowest-index asserted select bit.
module prio_issue_buffer_pmux #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic [N-1:0]        sel_i,
    input  logic [N-1:0][W-1:0] data_i,
    output logic [W-1:0]        data_o
);

    always_comb begin
        data_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel_i[i]) data_o = data_i[i];
        end
    end

endmodule

// File: rtl/prio_issue_buffer.sv
// Slot buffer: enqueue into lowest free slot, dequeue lowest valid slot via PriorityMux.
// Define PRIO_ISSUE_BUFFER_BYPASS_EN for an empty-buffer enq-to-deq pass-through.
module prio_issue_buffer
    import prio_issue_buffer_pkg::*;
#(
    parameter int Entries   = 8,
    parameter int DataWidth = 8,
    parameter int CntWidth  = $clog2(Entries + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        enq_valid_i,
    output logic                        enq_ready_o,
    input  logic [DataWidth-1:0]        enq_data_i,
    output logic                        deq_valid_o,
    input  logic                        deq_ready_i,
    output logic [DataWidth-1:0]        deq_data_o,
    output logic [$clog2(Entries)-1:0]  deq_idx_o,
    output logic [Entries-1:0]          valid_mask_o,
    output logic [CntWidth-1:0]         count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int IdxW = $clog2(Entries);

    if (Entries < 2 || Entries >= MaxEntries) begin : g_bad_entries
        $error("prio_issue_buffer: Entries out of range");
    end

    logic [Entries-1:0]                valid_q, valid_d;
    logic [Entries-1:0][DataWidth-1:0] data_q;
    logic [CntWidth-1:0]               count_q, count_d;

    logic [MaxEntries-1:0] sel_ext, alloc_ext;
    logic [MaxIdxW-1:0]    sel_bin_ext;
    logic [Entries-1:0]    sel_oh, alloc_oh;
    logic [DataWidth-1:0]  mux_data;
    logic                  any_valid, enq_fire, deq_fire;

    assign sel_ext     = lowest_one_oh(MaxEntries'(valid_q));
    assign alloc_ext   = lowest_one_oh(MaxEntries'(~valid_q));
    assign sel_oh      = sel_ext[Entries-1:0];
    assign alloc_oh    = alloc_ext[Entries-1:0];
    assign sel_bin_ext = oh2bin(sel_ext);
    assign any_valid   = |valid_q;

    logic unused_hi;
    assign unused_hi = ^{sel_ext[MaxEntries-1:Entries], alloc_ext[MaxEntries-1:Entries],
                         sel_bin_ext[MaxIdxW-1:IdxW]};

    prio_issue_buffer_pmux #(.N(Entries), .W(DataWidth)) u_pmux (
        .sel_i  (valid_q),
        .data_i (data_q),
        .data_o (mux_data)
    );

    assign full_o       = (count_q == CntWidth'(Entries));
    assign empty_o      = (count_q == '0);
    assign enq_ready_o  = ~full_o;
    assign count_o      = count_q;
    assign valid_mask_o = valid_q;

    // Slot dequeue only ever targets a stored entry; a bypassed payload never occupies one.
    assign deq_fire = any_valid & deq_ready_i & ~flush_i;

`ifdef PRIO_ISSUE_BUFFER_BYPASS_EN
    logic bypass;
    assign bypass      = ~any_valid & enq_valid_i & ~flush_i;
    assign deq_valid_o = any_valid | bypass;
    assign deq_data_o  = bypass ? enq_data_i : mux_data;
    assign deq_idx_o   = bypass ? '0 : sel_bin_ext[IdxW-1:0];
    assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i & ~(bypass & deq_ready_i);
`else
    assign deq_valid_o = any_valid;
    assign deq_data_o  = mux_data;
    assign deq_idx_o   = sel_bin_ext[IdxW-1:0];
    assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i;
`endif

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            if (enq_fire) valid_d = valid_d | alloc_oh;
            if (deq_fire) valid_d = valid_d & ~sel_oh;
            if (enq_fire && !deq_fire)      count_d = count_q + CntWidth'(1);
            else if (!enq_fire && deq_fire) count_d = count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; only the valid vector qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Entries; i++) begin
            if (enq_fire && alloc_oh[i]) data_q[i] <= enq_data_i;
        end
    end

endmodule

// File: tb/tb_prio_issue_buffer.sv
// Directed bench for prio_issue_buffer (default 8 entries x 8 bits).
module tb_prio_issue_buffer;

    localparam int Entries = 8;
    localparam int DW      = 8;
    localparam int CW      = $clog2(Entries + 1);

    logic            clk = 1'b0;
    logic            rst, flush_i, enq_valid_i, deq_ready_i;
    logic            enq_ready_o, deq_valid_o, full_o, empty_o;
    logic [DW-1:0]   enq_data_i, deq_data_o;
    logic [2:0]      deq_idx_o;
    logic [Entries-1:0] valid_mask_o;
    logic [CW-1:0]   count_o;

    int checks = 0;
    int errors = 0;

    prio_issue_buffer #(.Entries(Entries), .DataWidth(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .enq_valid_i  (enq_valid_i),
        .enq_ready_o  (enq_ready_o),
        .enq_data_i   (enq_data_i),
        .deq_valid_o  (deq_valid_o),
        .deq_ready_i  (deq_ready_i),
        .deq_data_o   (deq_data_o),
        .deq_idx_o    (deq_idx_o),
        .valid_mask_o (valid_mask_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1ns later; the occupancy invariant is checked every step.
    task automatic step();
        @(posedge clk);
        #1;
        check("count_eq_popcount", 32'(count_o), 32'($countones(valid_mask_o)));
    endtask

    task automatic idle();
        flush_i = 0; enq_valid_i = 0; deq_ready_i = 0; enq_data_i = '0;
    endtask

    task automatic enq(input logic [DW-1:0] d);
        enq_valid_i = 1; enq_data_i = d;
        step();
        enq_valid_i = 0;
    endtask

    initial begin
        rst = 1; idle();
        step(); step();
        rst = 0;
        check("rst_mask",      32'(valid_mask_o), 32'h0);
        check("rst_count",     32'(count_o),      32'd0);
        check("rst_full",      32'(full_o),       32'd0);
        check("rst_empty",     32'(empty_o),      32'd1);
        check("rst_enq_ready", 32'(enq_ready_o),  32'd1);
        check("rst_deq_valid", 32'(deq_valid_o),  32'd0);

        // Back-to-back enqueue with consumer stalled
        enq(8'h11); enq(8'h22); enq(8'h33);
        check("abc_mask",  32'(valid_mask_o), 32'h07);
        check("abc_count", 32'(count_o),      32'd3);
        check("abc_data",  32'(deq_data_o),   32'h11);
        check("abc_idx",   32'(deq_idx_o),    32'd0);
        check("abc_dvld",  32'(deq_valid_o),  32'd1);

        // Fill to full, then enq+deq while full
        for (int i = 0; i < 5; i++) enq(8'h40 + 8'(i));
        check("full_flag",  32'(full_o),      32'd1);
        check("full_ready", 32'(enq_ready_o), 32'd0);
        check("full_count", 32'(count_o),     32'd8);
        enq_valid_i = 1; enq_data_i = 8'h99; deq_ready_i = 1;
        step();
        deq_ready_i = 0;
        check("full_deq_count", 32'(count_o),      32'd7);
        check("full_deq_mask",  32'(valid_mask_o), 32'hFE);
        check("full_deq_ready", 32'(enq_ready_o),  32'd1);
        step();
        enq_valid_i = 0;
        check("refill_mask", 32'(valid_mask_o), 32'hFF);
        check("refill_idx",  32'(deq_idx_o),    32'd0);
        check("refill_data", 32'(deq_data_o),   32'h99);

        flush_i = 1; step(); flush_i = 0;
        check("flush1_mask", 32'(valid_mask_o), 32'h0);

        // Build slots {0,2}, then dequeue slot 0 while enqueuing
        enq(8'hA0); enq(8'hA1); enq(8'hA2);
        deq_ready_i = 1; step(); step(); deq_ready_i = 0;
        check("hole_mask", 32'(valid_mask_o), 32'h04);
        enq(8'hB0);
        check("s02_mask", 32'(valid_mask_o), 32'h05);
        check("s02_data", 32'(deq_data_o),   32'hB0);
        enq_valid_i = 1; enq_data_i = 8'h44; deq_ready_i = 1;
        step();
        idle();
        check("swap_mask",  32'(valid_mask_o), 32'h06);
        check("swap_count", 32'(count_o),      32'd2);
        check("swap_idx",   32'(deq_idx_o),    32'd1);
        check("swap_data",  32'(deq_data_o),   32'h44);

        // Four valid, flush with both handshakes offered
        enq(8'h55); enq(8'h66);
        check("four_mask", 32'(valid_mask_o), 32'h0F);
        flush_i = 1; enq_valid_i = 1; enq_data_i = 8'h77; deq_ready_i = 1;
        step();
        idle();
        check("flush_mask",  32'(valid_mask_o), 32'h0);
        check("flush_count", 32'(count_o),      32'd0);
        check("flush_empty", 32'(empty_o),      32'd1);
        check("flush_dvld",  32'(deq_valid_o),  32'd0);

        // Reset with enqueue and flush also active
        enq(8'h12); enq(8'h34);
        rst = 1; flush_i = 1; enq_valid_i = 1; enq_data_i = 8'h56; deq_ready_i = 1;
        step();
        rst = 0; idle();
        check("mrst_mask",  32'(valid_mask_o), 32'h0);
        check("mrst_count", 32'(count_o),      32'd0);
        check("mrst_empty", 32'(empty_o),      32'd1);
        check("mrst_full",  32'(full_o),       32'd0);
        check("mrst_ready", 32'(enq_ready_o),  32'd1);
        check("mrst_dvld",  32'(deq_valid_o),  32'd0);

        // Empty buffer: enqueue with consumer ready
        enq_valid_i = 1; enq_data_i = 8'h55; deq_ready_i = 1;
        #1;
`ifdef PRIO_ISSUE_BUFFER_BYPASS_EN
        check("byp_dvld", 32'(deq_valid_o), 32'd1);
        check("byp_data", 32'(deq_data_o),  32'h55);
        check("byp_idx",  32'(deq_idx_o),   32'd0);
        step();
        idle();
        check("byp_count", 32'(count_o),    32'd0);
        check("byp_dvld1", 32'(deq_valid_o), 32'd0);
`else
        check("nobyp_dvld0", 32'(deq_valid_o), 32'd0);
        step();
        idle();
        check("nobyp_dvld1", 32'(deq_valid_o), 32'd1);
        check("nobyp_data",  32'(deq_data_o),  32'h55);
        check("nobyp_count", 32'(count_o),     32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
